// File: rtl/write_back_mc_if.sv
// ----------------------------------------------------------------------------
// write_back_mc_if
//   Bundles everything the write-back stage exchanges with its neighbours:
//   the MEM/WB pipeline register, the per-channel memory read returns, and the
//   ID-stage regfile write port.
//
//   Parameters
//     WIDTH     data/register width
//     NUM_MEMS  number of memory read channels
//
//   master : the pipeline/memory side (drives MEM/WB and read data).
//   slave  : the write-back stage itself.
//
//   Signals
//     valid_MEMWB, ALU_out_MEMWB, pc_4_MEMWB, reg_wr_ctrl_MEMWB, funct3_MEMWB,
//     byte_offset_MEMWB, mem_sel, rd_MEMWB, reg_wr_en_MEMWB, halt_MEM
//                                     -> MEM/WB instruction fields
//     mem_rd_data, mem_rd_valid       -> memory channel returns
//     reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID, halt_WB, stall_WB, load_err
//                                     -> write-back results and status
// ----------------------------------------------------------------------------
interface write_back_mc_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_MEMS = 4
);
    localparam int SEL_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

    logic                      valid_MEMWB;
    logic [WIDTH-1:0]          ALU_out_MEMWB;
    logic [WIDTH-1:0]          pc_4_MEMWB;
    logic [1:0]                reg_wr_ctrl_MEMWB;
    logic [2:0]                funct3_MEMWB;
    logic [1:0]                byte_offset_MEMWB;
    logic [SEL_W-1:0]          mem_sel;
    logic [4:0]                rd_MEMWB;
    logic                      reg_wr_en_MEMWB;
    logic                      halt_MEM;
    logic [NUM_MEMS*WIDTH-1:0] mem_rd_data;
    logic [NUM_MEMS-1:0]       mem_rd_valid;

    logic [WIDTH-1:0]          reg_wr_data_WBID;
    logic [4:0]                rd_WBID;
    logic                      reg_wr_en_WBID;
    logic                      halt_WB;
    logic                      stall_WB;
    logic                      load_err;

    modport master (
        output valid_MEMWB, ALU_out_MEMWB, pc_4_MEMWB, reg_wr_ctrl_MEMWB,
               funct3_MEMWB, byte_offset_MEMWB, mem_sel, rd_MEMWB,
               reg_wr_en_MEMWB, halt_MEM, mem_rd_data, mem_rd_valid,
        input  reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID, halt_WB,
               stall_WB, load_err
    );

    modport slave (
        input  valid_MEMWB, ALU_out_MEMWB, pc_4_MEMWB, reg_wr_ctrl_MEMWB,
               funct3_MEMWB, byte_offset_MEMWB, mem_sel, rd_MEMWB,
               reg_wr_en_MEMWB, halt_MEM, mem_rd_data, mem_rd_valid,
        output reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID, halt_WB,
               stall_WB, load_err
    );
endinterface

// File: rtl/write_back_mc.sv
// ----------------------------------------------------------------------------
// write_back_mc
//   Multi-channel, variable-latency write-back stage. Picks the regfile write
//   source (ALU, PC+4, load data or zero), aligns and extends sub-word loads
//   taken from one of NUM_MEMS memory channels, and stalls upstream while the
//   selected channel has not returned data, giving up after TIMEOUT cycles.
//   Regfile write port outputs are registered.
//
//   Ports
//     clk  in  clock, rising edge
//     rst  in  asynchronous reset, active-high
//     bus  slave modport of write_back_mc_if (MEM/WB fields, memory returns,
//          regfile write port, halt_WB, stall_WB, load_err)
//
//   Parameters: WIDTH, NUM_MEMS, MEM_PRESENT (populated-channel mask), TIMEOUT.
//
//   Optional build macro WB_MISALIGN_TRAP_EN: misaligned loads (LW with a
//   non-zero offset, LH/LHU at offset 3) retire immediately with no register
//   write and a load_err pulse. Without it, LW ignores the offset and LH/LHU
//   round the offset down to a half-word boundary.
// ----------------------------------------------------------------------------
module write_back_mc #(
    parameter int                  WIDTH       = 32,
    parameter int                  NUM_MEMS    = 4,
    parameter logic [NUM_MEMS-1:0] MEM_PRESENT = 4'b1001,
    parameter int                  TIMEOUT     = 15
) (
    input  logic            clk,
    input  logic            rst,
    write_back_mc_if.slave  bus
);
    localparam int SEL_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
    // Channel table is padded to the full select range so out-of-range
    // selects land on "absent" entries instead of indexing past the mask.
    localparam int CHANS = 1 << SEL_W;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CTRL_ALU  = 2'd0;
    localparam logic [1:0] CTRL_PC4  = 2'd1;
    localparam logic [1:0] CTRL_LOAD = 2'd2;

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    // ------------------------------------------------------------------
    // Per-channel views
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] chan_data [CHANS];
    logic [CHANS-1:0] chan_present;
    logic [CHANS-1:0] chan_valid;

    generate
        for (genvar gi = 0; gi < CHANS; gi++) begin : g_chan
            if (gi < NUM_MEMS) begin : g_real
                assign chan_data[gi]    = bus.mem_rd_data[gi*WIDTH +: WIDTH];
                assign chan_present[gi] = MEM_PRESENT[gi];
                assign chan_valid[gi]   = bus.mem_rd_valid[gi];
            end else begin : g_pad
                assign chan_data[gi]    = '0;
                assign chan_present[gi] = 1'b0;
                assign chan_valid[gi]   = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load alignment / extension
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] align_load(
        input logic [WIDTH-1:0] word,
        input logic [2:0]       funct3,
        input logic [1:0]       off
    );
        logic [WIDTH-1:0] byte_sh;
        logic [WIDTH-1:0] half_sh;
        logic [1:0]       half_off;
`ifdef WB_MISALIGN_TRAP_EN
        // Offset 3 never reaches here for half-words; offset 1 is a legal
        // in-word half-word.
        half_off = off;
`else
        half_off = off & 2'b10;
`endif
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {half_off, 3'b000};
        case (funct3)
            3'b000:  align_load = {{(WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  align_load = {{(WIDTH-16){half_sh[15]}}, half_sh[15:0]};
            3'b010:  align_load = word;
            3'b100:  align_load = {{(WIDTH-8){1'b0}}, byte_sh[7:0]};
            3'b101:  align_load = {{(WIDTH-16){1'b0}}, half_sh[15:0]};
            default: align_load = '0;
        endcase
    endfunction

`ifdef WB_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        return ((funct3 == 3'b010) && (off != 2'b00)) ||
               (((funct3 == 3'b001) || (funct3 == 3'b101)) && (off == 2'b11));
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and captured load context
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] sel_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       off_reg;
    logic [4:0]       rd_reg;
    logic             wr_en_reg;
    logic             halt_reg;

    logic [WIDTH-1:0] wr_data_reg;
    logic [4:0]       rd_out_reg;
    logic             wr_en_out_reg;
    logic             halt_wb_reg;
    logic             load_err_reg;

    logic             capture;
    logic             stall;
    logic             retire;
    logic [WIDTH-1:0] ret_data;
    logic [4:0]       ret_rd;
    logic             ret_wr_en;
    logic             ret_halt;
    logic             ret_err;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        stall      = 1'b0;
        retire     = 1'b0;
        ret_data   = '0;
        ret_rd     = bus.rd_MEMWB;
        ret_wr_en  = bus.reg_wr_en_MEMWB;
        ret_halt   = bus.halt_MEM;
        ret_err    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.valid_MEMWB) begin
                    if (bus.reg_wr_ctrl_MEMWB != CTRL_LOAD) begin
                        retire = 1'b1;
                        case (bus.reg_wr_ctrl_MEMWB)
                            CTRL_ALU: ret_data = bus.ALU_out_MEMWB;
                            CTRL_PC4: ret_data = bus.pc_4_MEMWB;
                            default:  ret_data = '0;
                        endcase
                    end
`ifdef WB_MISALIGN_TRAP_EN
                    else if (is_misaligned(bus.funct3_MEMWB, bus.byte_offset_MEMWB)) begin
                        retire    = 1'b1;
                        ret_wr_en = 1'b0;
                        ret_err   = 1'b1;
                    end
`endif
                    else if (!chan_present[bus.mem_sel]) begin
                        retire  = 1'b1;
                        ret_err = 1'b1;
                    end else if (chan_valid[bus.mem_sel]) begin
                        retire   = 1'b1;
                        ret_data = align_load(chan_data[bus.mem_sel],
                                              bus.funct3_MEMWB,
                                              bus.byte_offset_MEMWB);
                    end else begin
                        stall      = 1'b1;
                        capture    = 1'b1;
                        cnt_next   = '0;
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                // The load stays parked in MEM/WB while we wait; its context
                // comes from the capture registers, not the live inputs.
                ret_rd    = rd_reg;
                ret_wr_en = wr_en_reg;
                ret_halt  = halt_reg;
                if (chan_valid[sel_reg]) begin
                    retire     = 1'b1;
                    ret_data   = align_load(chan_data[sel_reg], funct3_reg, off_reg);
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    retire     = 1'b1;
                    ret_err    = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall    = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg    <= '0;
            funct3_reg <= '0;
            off_reg    <= '0;
            rd_reg     <= '0;
            wr_en_reg  <= 1'b0;
            halt_reg   <= 1'b0;
        end else if (capture) begin
            sel_reg    <= bus.mem_sel;
            funct3_reg <= bus.funct3_MEMWB;
            off_reg    <= bus.byte_offset_MEMWB;
            rd_reg     <= bus.rd_MEMWB;
            wr_en_reg  <= bus.reg_wr_en_MEMWB;
            halt_reg   <= bus.halt_MEM;
        end
    end

    // Data and rd hold between retires; the strobe and error are pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_data_reg   <= '0;
            rd_out_reg    <= '0;
            wr_en_out_reg <= 1'b0;
            halt_wb_reg   <= 1'b0;
            load_err_reg  <= 1'b0;
        end else if (retire) begin
            wr_data_reg   <= ret_data;
            rd_out_reg    <= ret_rd;
            wr_en_out_reg <= ret_wr_en && (ret_rd != 5'd0);
            load_err_reg  <= ret_err;
            if (ret_halt) begin
                halt_wb_reg <= 1'b1;
            end
        end else begin
            wr_en_out_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end
    end

    assign bus.reg_wr_data_WBID = wr_data_reg;
    assign bus.rd_WBID          = rd_out_reg;
    assign bus.reg_wr_en_WBID   = wr_en_out_reg;
    assign bus.halt_WB          = halt_wb_reg;
    assign bus.load_err         = load_err_reg;
    assign bus.stall_WB         = stall;

endmodule

// File: tb/tb_write_back_mc.sv
// ----------------------------------------------------------------------------
// tb_write_back_mc
//   Directed-vector bench for write_back_mc (WIDTH=32, NUM_MEMS=4,
//   MEM_PRESENT=4'b1001, TIMEOUT=15). Inputs change on the falling edge;
//   stall_WB is sampled 1ns after that, registered outputs 1ns after the
//   rising edge.
// ----------------------------------------------------------------------------
module tb_write_back_mc;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    write_back_mc_if #(.WIDTH(32), .NUM_MEMS(4)) bus ();

    write_back_mc #(
        .WIDTH(32),
        .NUM_MEMS(4),
        .MEM_PRESENT(4'b1001),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] ctrl,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [2:0] f3, input logic [1:0] off,
                         input logic [1:0] sel, input logic [4:0] rd,
                         input logic wen, input logic halt);
        bus.valid_MEMWB       = v;
        bus.reg_wr_ctrl_MEMWB = ctrl;
        bus.ALU_out_MEMWB     = alu;
        bus.pc_4_MEMWB        = pc4;
        bus.funct3_MEMWB      = f3;
        bus.byte_offset_MEMWB = off;
        bus.mem_sel           = sel;
        bus.rd_MEMWB          = rd;
        bus.reg_wr_en_MEMWB   = wen;
        bus.halt_MEM          = halt;
        $display("txn t=%0t valid=%0b ctrl=%0d f3=%0d off=%0d sel=%0d rd=%0d halt=%0b",
                 $time, v, ctrl, f3, off, sel, rd, halt);
    endtask

    task automatic set_chan(input int idx, input logic [31:0] d, input logic v);
        bus.mem_rd_data[idx*32 +: 32] = d;
        bus.mem_rd_valid[idx]         = v;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0) $display("FAIL rst_data: got %h want 0", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd0) $display("FAIL rst_rd: got %0d want 0", bus.rd_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL rst_wen: got %b want 0", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.halt_WB !== 1'b0) $display("FAIL rst_halt: got %b want 0", bus.halt_WB); else n_pass++;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.stall_WB); else n_pass++;
        n_checks++; if (bus.load_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.load_err); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        // ALU result, then PC+4 back to back, idle, ctrl=3, rd=0.
        @(negedge clk); drive(1, 2'd0, 32'h1234, 32'h0, 3'd0, 2'd0, 2'd0, 5'd5, 1, 0);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL alu_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b1) $display("FAIL alu_wen: got %b want 1", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h1234) $display("FAIL alu_data: got %h want 00001234", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd5) $display("FAIL alu_rd: got %0d want 5", bus.rd_WBID); else n_pass++;

        @(negedge clk); drive(1, 2'd1, 32'hDEAD, 32'h100, 3'd0, 2'd0, 2'd0, 5'd6, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b1) $display("FAIL pc4_wen: got %b want 1", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h100) $display("FAIL pc4_data: got %h want 00000100", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd6) $display("FAIL pc4_rd: got %0d want 6", bus.rd_WBID); else n_pass++;

        @(negedge clk); drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL pulse_wen: got %b want 0", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h100) $display("FAIL hold_data: got %h want 00000100", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd6) $display("FAIL hold_rd: got %0d want 6", bus.rd_WBID); else n_pass++;

        @(negedge clk); drive(1, 2'd3, 32'hFFFF, 32'h44, 3'd0, 2'd0, 2'd0, 5'd7, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0) $display("FAIL ctrl3_data: got %h want 0", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b1) $display("FAIL ctrl3_wen: got %b want 1", bus.reg_wr_en_WBID); else n_pass++;

        @(negedge clk); drive(1, 2'd0, 32'h55, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL rd0_wen: got %b want 0", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h55) $display("FAIL rd0_data: got %h want 00000055", bus.reg_wr_data_WBID); else n_pass++;
    endtask

    task automatic test_load_hit();
        set_chan(0, 32'h0000_8000, 1);
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b000, 2'd1, 2'd0, 5'd7, 1, 0);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL lb_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd7) $display("FAIL lb_rd: got %0d want 7", bus.rd_WBID); else n_pass++;

        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b100, 2'd1, 2'd0, 5'd8, 1, 0);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL lbu_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", bus.reg_wr_data_WBID); else n_pass++;

        set_chan(0, 32'h8001_0000, 1);
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b001, 2'd2, 2'd0, 5'd8, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'hFFFF_8001) $display("FAIL lh_data: got %h want ffff8001", bus.reg_wr_data_WBID); else n_pass++;

        @(negedge clk); drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);
        set_chan(0, 32'h0, 0);
    endtask

    task automatic test_load_wait();
        set_chan(3, 32'hBEEF_0000, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drive(1, 2'd2, 32'h0, 32'h0, 3'b101, 2'd2, 2'd3, 5'd9, 1, 0);
            else        drive(0, 2'd0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0, 5'd0, 0, 0);
            #1;
            n_checks++; if (bus.stall_WB !== 1'b1) $display("FAIL wait_stall[%0d]: got %b want 1", k, bus.stall_WB); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL wait_wen[%0d]: got %b want 0", k, bus.reg_wr_en_WBID); else n_pass++;
        end
        @(negedge clk); set_chan(3, 32'hBEEF_0000, 1);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL wait_done_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0000_BEEF) $display("FAIL lhu_data: got %h want 0000beef", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd9) $display("FAIL lhu_rd: got %0d want 9", bus.rd_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b1) $display("FAIL lhu_wen: got %b want 1", bus.reg_wr_en_WBID); else n_pass++;
        @(negedge clk); set_chan(3, 32'h0, 0);
    endtask

    // Load presented on cycle 0; cycles 0..14 stall, cycle 15 is the
    // timeout cycle where data may still arrive and win.
    task automatic test_timeout(input logic data_on_last);
        set_chan(0, 32'hCAFE_F00D, 0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) drive(1, 2'd2, 32'h0, 32'h0, 3'b010, 2'd0, 2'd0, 5'd10, 1, 0);
            #1;
            n_checks++; if (bus.stall_WB !== 1'b1) $display("FAIL to_stall[%0d]: got %b want 1", c, bus.stall_WB); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (bus.load_err !== 1'b0) $display("FAIL to_early_err[%0d]: got %b want 0", c, bus.load_err); else n_pass++;
        end
        @(negedge clk);
        if (data_on_last) set_chan(0, 32'hCAFE_F00D, 1);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL to_last_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== (data_on_last ? 32'hCAFE_F00D : 32'h0)) $display("FAIL to_data: got %h want %h", bus.reg_wr_data_WBID, (data_on_last ? 32'hCAFE_F00D : 32'h0)); else n_pass++;
        n_checks++; if (bus.load_err !== !data_on_last) $display("FAIL to_err: got %b want %b", bus.load_err, !data_on_last); else n_pass++;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b1) $display("FAIL to_wen: got %b want 1", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd10) $display("FAIL to_rd: got %0d want 10", bus.rd_WBID); else n_pass++;
        @(negedge clk); drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);
        set_chan(0, 32'h0, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.load_err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", bus.load_err); else n_pass++;
    endtask

    task automatic test_absent();
        set_chan(1, 32'h1234_5678, 1);
        set_chan(2, 32'h8765_4321, 1);
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b010, 2'd0, 2'd1, 5'd11, 1, 0);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL abs_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0) $display("FAIL abs_data: got %h want 0", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.load_err !== 1'b1) $display("FAIL abs_err: got %b want 1", bus.load_err); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd11) $display("FAIL abs_rd: got %0d want 11", bus.rd_WBID); else n_pass++;
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b100, 2'd0, 2'd2, 5'd12, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.load_err !== 1'b1) $display("FAIL abs2_err: got %b want 1", bus.load_err); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd12) $display("FAIL abs2_rd: got %0d want 12", bus.rd_WBID); else n_pass++;
        @(negedge clk); drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);
        set_chan(1, 32'h0, 0);
        set_chan(2, 32'h0, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.load_err !== 1'b0) $display("FAIL abs_err_pulse: got %b want 0", bus.load_err); else n_pass++;
    endtask

    task automatic test_misalign();
        set_chan(0, 32'h1122_3344, 1);
`ifdef WB_MISALIGN_TRAP_EN
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b010, 2'd2, 2'd0, 5'd13, 1, 0);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL trap_lw_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.load_err !== 1'b1) $display("FAIL trap_lw_err: got %b want 1", bus.load_err); else n_pass++;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL trap_lw_wen: got %b want 0", bus.reg_wr_en_WBID); else n_pass++;
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b001, 2'd3, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.load_err !== 1'b1) $display("FAIL trap_lh_err: got %b want 1", bus.load_err); else n_pass++;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL trap_lh_wen: got %b want 0", bus.reg_wr_en_WBID); else n_pass++;
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b001, 2'd1, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0000_2233) $display("FAIL trap_lh1_data: got %h want 00002233", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.load_err !== 1'b0) $display("FAIL trap_lh1_err: got %b want 0", bus.load_err); else n_pass++;
`else
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b010, 2'd2, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h1122_3344) $display("FAIL lw_off_data: got %h want 11223344", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.load_err !== 1'b0) $display("FAIL lw_off_err: got %b want 0", bus.load_err); else n_pass++;
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b001, 2'd3, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0000_1122) $display("FAIL lh3_data: got %h want 00001122", bus.reg_wr_data_WBID); else n_pass++;
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b101, 2'd1, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0000_3344) $display("FAIL lhu1_data: got %h want 00003344", bus.reg_wr_data_WBID); else n_pass++;
`endif
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b000, 2'd3, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0000_0011) $display("FAIL lb3_data: got %h want 00000011", bus.reg_wr_data_WBID); else n_pass++;
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b011, 2'd0, 2'd0, 5'd13, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0) $display("FAIL badf3_data: got %h want 0", bus.reg_wr_data_WBID); else n_pass++;
        @(negedge clk); drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);
        set_chan(0, 32'h0, 0);
    endtask

    task automatic test_halt();
        set_chan(0, 32'h77, 0);
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b010, 2'd0, 2'd0, 5'd14, 1, 1);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b1) $display("FAIL halt_stall: got %b want 1", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.halt_WB !== 1'b0) $display("FAIL halt_early: got %b want 0", bus.halt_WB); else n_pass++;
        @(negedge clk); set_chan(0, 32'h77, 1);
        @(posedge clk); #1;
        n_checks++; if (bus.halt_WB !== 1'b1) $display("FAIL halt_set: got %b want 1", bus.halt_WB); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h77) $display("FAIL halt_data: got %h want 00000077", bus.reg_wr_data_WBID); else n_pass++;
        @(negedge clk); set_chan(0, 32'h0, 0);
        drive(1, 2'd0, 32'h99, 32'h0, 3'd0, 2'd0, 2'd0, 5'd15, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.halt_WB !== 1'b1) $display("FAIL halt_sticky: got %b want 1", bus.halt_WB); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        set_chan(3, 32'hAAAA_5555, 0);
        @(negedge clk); drive(1, 2'd2, 32'h0, 32'h0, 3'b010, 2'd0, 2'd3, 5'd16, 1, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.stall_WB !== 1'b1) $display("FAIL riw_in_wait: got %b want 1", bus.stall_WB); else n_pass++;
        @(negedge clk);
        drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL riw_stall: got %b want 0", bus.stall_WB); else n_pass++;
        n_checks++; if (bus.halt_WB !== 1'b0) $display("FAIL riw_halt: got %b want 0", bus.halt_WB); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0) $display("FAIL riw_data: got %h want 0", bus.reg_wr_data_WBID); else n_pass++;
        n_checks++; if (bus.rd_WBID !== 5'd0) $display("FAIL riw_rd: got %0d want 0", bus.rd_WBID); else n_pass++;
        @(negedge clk); rst = 1'b0;
        set_chan(3, 32'hAAAA_5555, 1);
        #1;
        n_checks++; if (bus.stall_WB !== 1'b0) $display("FAIL riw_idle_stall: got %b want 0", bus.stall_WB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.reg_wr_en_WBID !== 1'b0) $display("FAIL riw_dropped_wen: got %b want 0", bus.reg_wr_en_WBID); else n_pass++;
        n_checks++; if (bus.reg_wr_data_WBID !== 32'h0) $display("FAIL riw_dropped_data: got %h want 0", bus.reg_wr_data_WBID); else n_pass++;
        @(negedge clk); set_chan(3, 32'h0, 0);
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        n_checks = 0;
        n_pass   = 0;
        bus.mem_rd_data  = '0;
        bus.mem_rd_valid = '0;
        drive(0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 5'd0, 0, 0);

        test_reset();
        test_alu();
        test_load_hit();
        test_load_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_absent();
        test_misalign();
        test_halt();
        test_reset_in_wait();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
